// File: rtl/ppi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ppi_pkg
// Purpose  : Shared types and constants for the 8255A-style PPI bus master.
// Revision : 1.0 - initial release
// ============================================================================
package ppi_pkg;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_SETUP  = 3'd2,
        ST_STROBE = 3'd3,
        ST_HOLD   = 3'd4,
        ST_ERR    = 3'd5
    } ppi_state_e;

    localparam logic [1:0] PPI_PORTA = 2'd0;
    localparam logic [1:0] PPI_PORTB = 2'd1;
    localparam logic [1:0] PPI_PORTC = 2'd2;
    localparam logic [1:0] PPI_CTRL  = 2'd3;

    // Mode 0, ports A, B and C all configured as inputs.
    localparam logic [7:0] PPI_DEFAULT_CW = 8'h9B;

    // The control register cannot be read back on an 8255A.
    function automatic logic ppi_is_bad_req(input logic wr, input logic [1:0] addr);
        return (!wr) && (addr == PPI_CTRL);
    endfunction

endpackage : ppi_pkg
`default_nettype wire

// File: rtl/ppi_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ppi_rr_arbiter
// Purpose  : Two-way round-robin grant; prio_i names the favoured requester.
// Revision : 1.0 - initial release
// ============================================================================
module ppi_rr_arbiter (
    input  logic [1:0] valid_i,
    input  logic       prio_i,
    input  logic       advance_i,
    output logic [1:0] grant_o,
    output logic       prio_nxt_o
);

    always_comb begin
        grant_o    = 2'b00;
        prio_nxt_o = prio_i;
        if (advance_i) begin
            if (&valid_i) begin
                grant_o = prio_i ? 2'b10 : 2'b01;
            end else begin
                grant_o = valid_i;
            end
            // After serving requester 0, requester 1 becomes favoured and vice versa.
            if (|valid_i) begin
                prio_nxt_o = grant_o[0];
            end
        end
    end

endmodule : ppi_rr_arbiter
`default_nettype wire

// File: rtl/ppi_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : ppi_bus_master
// Purpose  : Timed nCs/nRe/nWr bus-cycle sequencer sharing one PPI between two
//            round-robin requesters, with a control-word write after reset.
// Revision : 1.0 - initial release
// ============================================================================
module ppi_bus_master
    import ppi_pkg::*;
#(
    parameter int         SETUP_CYCLES  = 1,
    parameter int         STROBE_CYCLES = 2,
    parameter int         HOLD_CYCLES   = 1,
    parameter bit         INIT_EN       = 1'b1,
    parameter logic [7:0] INIT_CW       = PPI_DEFAULT_CW
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [1:0]  req_wr,
    input  logic [3:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic        rsp_id,
    output logic        rsp_err,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        nCs,
    output logic        nRe,
    output logic        nWr,
    output logic [1:0]  A,
    output logic [7:0]  D_out,
    output logic        D_oe,
    input  logic [7:0]  D_in
);

    localparam int MAX_SH  = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
    localparam int MAX_CYC = (STROBE_CYCLES > MAX_SH) ? STROBE_CYCLES : MAX_SH;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
    localparam ppi_state_e       RESET_ST  = INIT_EN ? ST_INIT : ST_IDLE;

    ppi_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prio_q, prio_d;
    logic [1:0]       addr_q, addr_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             wr_q, wr_d;
    logic             id_q, id_d;
    logic             init_q, init_d;
    logic [7:0]       rdata_q, rdata_d;

    logic             ncs_q, nre_q, nwr_q, doe_q, busy_q;
    logic             rsp_valid_q, rsp_id_q, rsp_err_q;
    logic [7:0]       rsp_rdata_q;

    logic [1:0]       grant;
    logic             accept;
    logic             gid;
    logic             sel_wr;
    logic [1:0]       sel_addr;
    logic [7:0]       sel_wdata;
    logic             finish;
    logic             rsp_fire;
    logic             bus_active_d;
    logic             cnt_zero;

    ppi_rr_arbiter u_arb (
        .valid_i    (req_valid),
        .prio_i     (prio_q),
        .advance_i  (state_q == ST_IDLE),
        .grant_o    (grant),
        .prio_nxt_o (prio_d)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);
    assign gid       = grant[1];
    assign sel_wr    = req_wr[gid];
    assign sel_addr  = gid ? req_addr[3:2]   : req_addr[1:0];
    assign sel_wdata = gid ? req_wdata[15:8] : req_wdata[7:0];
    assign cnt_zero  = (cnt_q == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        id_d    = id_q;
        init_d  = init_q;
        rdata_d = rdata_q;
        finish  = 1'b0;
        case (state_q)
            ST_INIT: begin
                state_d = ST_SETUP;
                cnt_d   = SETUP_LD;
                addr_d  = PPI_CTRL;
                wdata_d = INIT_CW;
                wr_d    = 1'b1;
                init_d  = 1'b1;
            end
            ST_IDLE: begin
                if (accept) begin
                    id_d = gid;
                    wr_d = sel_wr;
                    if (ppi_is_bad_req(sel_wr, sel_addr)) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                        addr_d  = sel_addr;
                        wdata_d = sel_wdata;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            ST_SETUP: begin
                if (cnt_zero) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_STROBE: begin
                if (cnt_zero) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                    // Sampled on the edge that raises the read strobe.
                    if (!wr_q) begin
                        rdata_d = D_in;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_zero) begin
                    state_d = ST_IDLE;
                    finish  = 1'b1;
                    init_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus_active_d = (state_d == ST_SETUP) || (state_d == ST_STROBE) ||
                          (state_d == ST_HOLD);
    assign rsp_fire     = (finish && !init_q) || (state_d == ST_ERR);

    // Bus pins are decoded from the next state so they toggle straight off flops.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= RESET_ST;
            cnt_q       <= '0;
            prio_q      <= 1'b0;
            addr_q      <= 2'd0;
            wdata_q     <= 8'd0;
            wr_q        <= 1'b0;
            id_q        <= 1'b0;
            init_q      <= 1'b0;
            rdata_q     <= 8'd0;
            ncs_q       <= 1'b1;
            nre_q       <= 1'b1;
            nwr_q       <= 1'b1;
            doe_q       <= 1'b0;
            busy_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            prio_q      <= prio_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wr_q        <= wr_d;
            id_q        <= id_d;
            init_q      <= init_d;
            rdata_q     <= rdata_d;
            ncs_q       <= !bus_active_d;
            nwr_q       <= !((state_d == ST_STROBE) && wr_d);
            nre_q       <= !((state_d == ST_STROBE) && !wr_d);
            doe_q       <= bus_active_d && wr_d;
            busy_q      <= (state_d != ST_IDLE);
            rsp_valid_q <= rsp_fire;
            rsp_id_q    <= rsp_fire ? id_d : 1'b0;
            rsp_err_q   <= (state_d == ST_ERR);
            rsp_rdata_q <= (finish && !init_q && !wr_q) ? rdata_q : 8'd0;
        end
    end

    assign nCs       = ncs_q;
    assign nRe       = nre_q;
    assign nWr       = nwr_q;
    assign D_oe      = doe_q;
    assign A         = addr_q;
    assign D_out     = wdata_q;
    assign busy      = busy_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule : ppi_bus_master
`default_nettype wire

// File: tb/tb_ppi_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_ppi_bus_master
// Purpose  : Directed and random requests checked against a cycle-schedule
//            model of the PPI bus master.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ppi_bus_master;

    localparam int N  = 4096;
    localparam int S  = 1;
    localparam int P  = 2;
    localparam int H  = 1;
    localparam int BIG = 1 << 30;

    logic        Clk;
    logic        Reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [1:0]  req_wr;
    logic [3:0]  req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid, rsp_id, rsp_err;
    logic [7:0]  rsp_rdata;
    logic        busy, nCs, nRe, nWr, D_oe;
    logic [1:0]  A;
    logic [7:0]  D_out, D_in;

    ppi_bus_master dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wr    (req_wr),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .busy      (busy),
        .nCs       (nCs),
        .nRe       (nRe),
        .nWr       (nWr),
        .A         (A),
        .D_out     (D_out),
        .D_oe      (D_oe),
        .D_in      (D_in)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        bit       wr;
        bit [1:0] addr;
        bit [7:0] data;
        int       gap;
    } req_t;

    req_t rq0[$];
    req_t rq1[$];

    // Expected pin values per cycle number.
    bit       e_ncs [N];
    bit       e_nre [N];
    bit       e_nwr [N];
    bit       e_doe [N];
    bit       e_rv  [N];
    bit       e_id  [N];
    bit       e_err [N];
    bit [1:0] e_a   [N];
    bit [7:0] e_d   [N];
    int       e_rds [N];
    bit [7:0] din_hist [N];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int free_cyc = BIG;
    int last_rsp = 0;
    int last_acc = 0;
    int n_acc = 0;
    int last_grant = 1;
    bit in_reset = 1'b1;
    bit rel_pending = 1'b0;
    bit din_force = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic clear_from(input int k);
        for (int i = k; i < N; i++) begin
            e_ncs[i] = 1'b1; e_nre[i] = 1'b1; e_nwr[i] = 1'b1; e_doe[i] = 1'b0;
            e_rv[i] = 1'b0;  e_id[i] = 1'b0;  e_err[i] = 1'b0;
            e_a[i] = 2'd0;   e_d[i] = 8'd0;   e_rds[i] = -1;
        end
    endtask

    // Bus occupancy and response of one transfer that starts (accept or init) at cycle t.
    task automatic schedule(input int t, input bit is_init, input bit [1:0] addr,
                            input bit [7:0] data, input bit wr, input bit id);
        if (!is_init && !wr && addr == 2'd3) begin
            e_rv[t+1] = 1'b1; e_id[t+1] = id; e_err[t+1] = 1'b1; e_rds[t+1] = -1;
            free_cyc = t + 2;
            last_rsp = t + 1;
        end else begin
            for (int c = t + 1; c <= t + S + P + H; c++) begin
                e_ncs[c] = 1'b0; e_a[c] = addr; e_doe[c] = wr; e_d[c] = data;
            end
            for (int c = t + S + 1; c <= t + S + P; c++) begin
                if (wr) e_nwr[c] = 1'b0;
                else    e_nre[c] = 1'b0;
            end
            free_cyc = t + 1 + S + P + H;
            if (!is_init) begin
                e_rv[free_cyc]  = 1'b1;
                e_id[free_cyc]  = id;
                e_err[free_cyc] = 1'b0;
                e_rds[free_cyc] = wr ? -1 : (t + S + P);
                last_rsp = free_cyc;
            end
        end
    endtask

    task automatic cycle();
        req_t       e;
        logic [1:0] exp_ready;
        int         g;
        @(posedge Clk);
        #1;
        cyc++;
        if (rel_pending) begin
            Reset = 1'b0;
            rel_pending = 1'b0;
            in_reset = 1'b0;
            last_grant = 1;
            schedule(cyc, 1'b1, 2'd3, 8'h9B, 1'b1, 1'b0);
        end
        D_in = din_force ? 8'hC3 : 8'($urandom);
        din_hist[cyc] = D_in;
        req_valid = 2'b00;
        for (int r = 0; r < 2; r++) begin
            if ((r == 0) ? (rq0.size() > 0) : (rq1.size() > 0)) begin
                e = (r == 0) ? rq0[0] : rq1[0];
                if (e.gap > 0) begin
                    e.gap--;
                    if (r == 0) rq0[0] = e; else rq1[0] = e;
                end else begin
                    req_valid[r]         = 1'b1;
                    req_wr[r]            = e.wr;
                    req_addr[2*r +: 2]   = e.addr;
                    req_wdata[8*r +: 8]  = e.data;
                end
            end
        end
        @(negedge Clk);
        exp_ready = 2'b00;
        g = 0;
        if (!in_reset && cyc >= free_cyc && req_valid != 2'b00) begin
            if (req_valid == 2'b11) g = (last_grant == 0) ? 1 : 0;
            else                    g = req_valid[1] ? 1 : 0;
            exp_ready[g] = 1'b1;
        end
        chk("req_ready", req_ready, exp_ready);
        chk("nCs", nCs, e_ncs[cyc]);
        chk("nRe", nRe, e_nre[cyc]);
        chk("nWr", nWr, e_nwr[cyc]);
        chk("D_oe", D_oe, e_doe[cyc]);
        chk("rsp_valid", rsp_valid, e_rv[cyc]);
        if (!e_ncs[cyc]) begin
            chk("A", A, e_a[cyc]);
            chk("busy", busy, 1);
        end
        if (e_doe[cyc]) chk("D_out", D_out, e_d[cyc]);
        if (e_rv[cyc]) begin
            chk("rsp_id", rsp_id, e_id[cyc]);
            chk("rsp_err", rsp_err, e_err[cyc]);
            chk("rsp_rdata", rsp_rdata, (e_rds[cyc] < 0) ? 8'd0 : din_hist[e_rds[cyc]]);
        end
        if (exp_ready != 2'b00) begin
            e = (g == 0) ? rq0.pop_front() : rq1.pop_front();
            last_grant = g;
            last_acc = cyc;
            n_acc++;
            schedule(cyc, 1'b0, e.addr, e.data, e.wr, g[0]);
        end
    endtask

    task automatic run_quiet(input int maxc);
        int n = 0;
        while ((rq0.size() > 0 || rq1.size() > 0 || cyc < free_cyc || cyc <= last_rsp)
               && n < maxc) begin
            cycle();
            n++;
        end
        chk("quiet_timeout", (n < maxc), 1);
        cycle();
        cycle();
    endtask

    task automatic push(input int r, input bit wr, input bit [1:0] addr,
                        input bit [7:0] data, input int gap);
        req_t e;
        e.wr = wr; e.addr = addr; e.data = data; e.gap = gap;
        if (r == 0) rq0.push_back(e); else rq1.push_back(e);
    endtask

    initial begin
        int acc0;
        int n;
        Reset = 1'b1;
        req_valid = 2'b00;
        req_wr = 2'b00;
        req_addr = 4'd0;
        req_wdata = 16'd0;
        D_in = 8'd0;
        clear_from(0);

        // Reset values
        cycle();
        cycle();
        chk("rst_A", A, 0);
        chk("rst_D_out", D_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);

        // Init control word, then requester 0 writes 5A to port A
        push(0, 1'b1, 2'd0, 8'h5A, 0);
        rel_pending = 1'b1;
        run_quiet(100);

        // Requester 1 reads port B with D_in held at C3
        din_force = 1'b1;
        push(1, 1'b0, 2'd1, 8'h00, 0);
        run_quiet(100);
        din_force = 1'b0;

        // Both requesters streaming four writes each
        for (int i = 0; i < 4; i++) begin
            push(0, 1'b1, 2'(i), 8'($urandom), 0);
            push(1, 1'b1, 2'(3 - i), 8'($urandom), 0);
        end
        run_quiet(200);

        // Rejected read of the control register
        push(0, 1'b0, 2'd3, 8'h00, 0);
        run_quiet(100);

        // Reset during the strobe of a write
        acc0 = n_acc;
        push(0, 1'b1, 2'd2, 8'hA5, 0);
        n = 0;
        while (n_acc == acc0 && n < 20) begin
            cycle();
            n++;
        end
        chk("accept_timeout", (n < 20), 1);
        cycle();
        cycle();
        chk("pre_reset_nWr", nWr, 0);
        Reset = 1'b1;
        #1;
        chk("async_nWr", nWr, 1);
        chk("async_nCs", nCs, 1);
        chk("async_D_oe", D_oe, 0);
        in_reset = 1'b1;
        free_cyc = BIG;
        last_rsp = 0;
        clear_from(cyc + 1);
        cycle();
        cycle();
        rel_pending = 1'b1;
        cycle();
        run_quiet(100);

        // Random traffic from both requesters
        for (int i = 0; i < 50; i++) begin
            push(0, 1'($urandom), 2'($urandom), 8'($urandom), int'($urandom_range(0, 4)));
            push(1, 1'($urandom), 2'($urandom), 8'($urandom), int'($urandom_range(0, 4)));
        end
        run_quiet(3000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ppi_bus_master
`default_nettype wire
